// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID decoupling queue.
// The master side is the fetch/decode environment and the slave side is the queue.
interface if_id_queue_if #(
    parameter int AW = 2
);
    logic          if_valid;
    logic [31:0]   if_pc;
    logic [31:0]   if_pc4;
    logic [31:0]   if_inst;
    logic          flush;
    logic          id_stall;
    logic          if_stall;
    logic          id_valid;
    logic [31:0]   id_pc;
    logic [31:0]   id_pc4;
    logic [31:0]   id_inst;
    logic [AW:0]   count;

    modport master (
        output if_valid, if_pc, if_pc4, if_inst, flush, id_stall,
        input  if_stall, id_valid, id_pc, id_pc4, id_inst, count
    );

    modport slave (
        input  if_valid, if_pc, if_pc4, if_inst, flush, id_stall,
        output if_stall, id_valid, id_pc, id_pc4, id_inst, count
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: show-ahead FIFO of {pc, pc4, inst} between fetch and decode.
// Full back-pressures fetch from registered state only; a taken branch flushes every entry.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         clrn,
    if_id_queue_if.slave bus
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } entry_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A full queue refuses fetch even when decode pops in the same cycle.
    assign push = bus.if_valid & ~full;
    assign pop  = ~empty & ~bus.id_stall;

    // Next-state for pointers and occupancy; flush wins over any push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem_q[wr_ptr_q] <= '{pc: bus.if_pc, pc4: bus.if_pc4, inst: bus.if_inst};
        end
    end

    // Show-ahead head entry; an empty queue presents a zero (nop) instruction.
    always_comb begin
        head = mem_q[rd_ptr_q];
        if (empty) begin
            head = '0;
        end
    end

    assign bus.id_valid = ~empty;
    assign bus.id_pc    = head.pc;
    assign bus.id_pc4   = head.pc4;
    assign bus.id_inst  = head.inst;
    assign bus.if_stall = full;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus randomized traffic against a queue model.
module tb_if_id_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    if_id_queue_if #(.AW(AW)) bus ();
    if_id_queue #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .clrn(clrn), .bus(bus));

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } ent_t;

    typedef struct packed {
        logic [AW:0] cnt;
        logic        full;
        logic        vld;
        logic        pop;
    } st_t;

    ent_t mq[$];
    ent_t sb[$];
    st_t  st_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit fl, input bit st);
        ent_t e;
        st_t  s;
        bit   do_pop;
        bit   do_push;
        @(posedge clk);
        #1;
        e.pc   = pc;
        e.pc4  = pc + 32'd4;
        e.inst = $urandom;
        bus.if_valid = v;
        bus.if_pc    = e.pc;
        bus.if_pc4   = e.pc4;
        bus.if_inst  = e.inst;
        bus.flush    = fl;
        bus.id_stall = st;
        s.cnt   = (AW+1)'(mq.size());
        s.full  = (mq.size() == DEPTH);
        s.vld   = (mq.size() != 0);
        do_pop  = !fl && (mq.size() != 0) && !st;
        do_push = !fl && v && (mq.size() < DEPTH);
        s.pop   = do_pop;
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) sb.push_back(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        st_q.push_back(s);
    endtask

    always @(negedge clk) begin : monitor
        st_t  s;
        ent_t e;
        if (mon_en && st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("count", 32'(bus.count), 32'(s.cnt));
            chk("if_stall", 32'(bus.if_stall), 32'(s.full));
            chk("id_valid", 32'(bus.id_valid), 32'(s.vld));
            if (!s.vld) begin
                chk("empty_inst", bus.id_inst, 32'h0);
                chk("empty_pc", bus.id_pc, 32'h0);
                chk("empty_pc4", bus.id_pc4, 32'h0);
            end
            if (s.pop && sb.size() > 0) begin
                e = sb.pop_front();
                chk("pop_pc", bus.id_pc, e.pc);
                chk("pop_pc4", bus.id_pc4, e.pc4);
                chk("pop_inst", bus.id_inst, e.inst);
            end
        end
    end

    initial begin
        logic [31:0] seq;
        bit          rv, rf, rs;
        clrn         = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_pc    = '0;
        bus.if_pc4   = '0;
        bus.if_inst  = '0;
        bus.flush    = 1'b0;
        bus.id_stall = 1'b0;
        #12;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_if_stall", 32'(bus.if_stall), 32'd0);
        chk("rst_id_inst", bus.id_inst, 32'h0);
        #5;
        clrn   = 1'b1;
        mon_en = 1'b1;

        // Reset mid-stream with three entries queued
        drive(1, 32'h0, 0, 1);
        drive(1, 32'h4, 0, 1);
        drive(1, 32'h8, 0, 1);
        drive(0, 32'h0, 0, 1);
        chk("t1_count_pre", 32'(bus.count), 32'd3);
        #2;
        mon_en = 1'b0;
        clrn   = 1'b0;
        #1;
        chk("t1_count", 32'(bus.count), 32'd0);
        chk("t1_id_valid", 32'(bus.id_valid), 32'd0);
        chk("t1_id_inst", bus.id_inst, 32'h0);
        mq.delete();
        sb.delete();
        st_q.delete();
        #1;
        clrn   = 1'b1;
        mon_en = 1'b1;

        // Fill to full, fifth push dropped
        drive(1, 32'h0, 0, 1);
        drive(1, 32'h4, 0, 1);
        drive(1, 32'h8, 0, 1);
        drive(1, 32'hC, 0, 1);
        drive(1, 32'h10, 0, 1);
        chk("t2_count", 32'(bus.count), 32'd4);
        chk("t2_if_stall", 32'(bus.if_stall), 32'd1);
        chk("t2_id_pc", bus.id_pc, 32'h0);
        drive(0, 32'h0, 0, 1);
        chk("t2_count_after_drop", 32'(bus.count), 32'd4);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 0, 0);
            chk("t3_id_pc", bus.id_pc, 32'(4 * i));
        end
        drive(0, 32'h0, 0, 1);
        chk("t3_id_valid", 32'(bus.id_valid), 32'd0);
        chk("t3_count", 32'(bus.count), 32'd0);
        chk("t3_id_inst", bus.id_inst, 32'h0);

        // Steady flow through pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'(4 * i), 0, 0);
            if (i >= 1) begin
                chk("t4_count", 32'(bus.count), 32'd1);
                chk("t4_id_pc", bus.id_pc, 32'(4 * (i - 1)));
            end
        end
        drive(0, 32'h0, 0, 0);
        drive(0, 32'h0, 0, 0);
        chk("t4_count_end", 32'(bus.count), 32'd0);

        // Flush with simultaneous push and pop
        drive(1, 32'h100, 0, 1);
        drive(1, 32'h104, 0, 1);
        drive(1, 32'h40, 1, 0);
        chk("t5_count_pre", 32'(bus.count), 32'd2);
        drive(0, 32'h0, 0, 1);
        chk("t5_count", 32'(bus.count), 32'd0);
        chk("t5_id_valid", 32'(bus.id_valid), 32'd0);
        drive(0, 32'h0, 0, 0);

        // Full with a pop in the same cycle: push refused, accepted next cycle
        drive(1, 32'h200, 0, 1);
        drive(1, 32'h204, 0, 1);
        drive(1, 32'h208, 0, 1);
        drive(1, 32'h20C, 0, 1);
        drive(1, 32'h50, 0, 0);
        chk("t6_count_full", 32'(bus.count), 32'd4);
        drive(1, 32'h50, 0, 1);
        chk("t6_count", 32'(bus.count), 32'd3);
        chk("t6_if_stall", 32'(bus.if_stall), 32'd0);
        drive(0, 32'h0, 0, 1);
        chk("t6_count_accept", 32'(bus.count), 32'd4);
        for (int i = 0; i < 5; i++) drive(0, 32'h0, 0, 0);
        chk("t6_count_end", 32'(bus.count), 32'd0);

        // Randomized traffic, including held flushes
        seq = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 9) < 7);
            rf = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 9) < 4);
            drive(rv, seq, rf, rs);
            seq = seq + 32'd4;
        end
        for (int i = 0; i < DEPTH + 2; i++) drive(0, 32'h0, 0, 0);
        @(negedge clk);
        #1;
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_model_empty", 32'(mq.size()), 32'd0);
        chk("final_count", 32'(bus.count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
